// File: rtl/alu_reg_integration.sv
// ============================================================================
// Module   : alu_reg_integration
// Purpose  : 16x16-bit register file feeding a CR16-style ALU with
//            single-cycle write-back and registered {N,Z,F,L,C} flags.
// Option   : define REG0_ZERO_EN to hardwire R0 to zero.
// Revision : 1.0
// ============================================================================
`default_nettype none

module alu_reg_integration (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] immediate,
  input  logic [4:0]  regEnables,
  input  logic [4:0]  buffAEnables,
  input  logic [4:0]  buffBEnables,
  input  logic        Cin,
  input  logic        regOrImmed,
  input  logic [3:0]  op,
  input  logic [3:0]  exop,
  output logic [4:0]  flagsOutput,
  output logic [15:0] regOut15
);

  localparam logic [3:0] c_AND  = 4'b0001;
  localparam logic [3:0] c_OR   = 4'b0010;
  localparam logic [3:0] c_XOR  = 4'b0011;
  localparam logic [3:0] c_LSH  = 4'b0100;
  localparam logic [3:0] c_ADD  = 4'b0101;
  localparam logic [3:0] c_ADDU = 4'b0110;
  localparam logic [3:0] c_ADDC = 4'b0111;
  localparam logic [3:0] c_LSHI = 4'b1000;
  localparam logic [3:0] c_SUB  = 4'b1001;
  localparam logic [3:0] c_SUBC = 4'b1010;
  localparam logic [3:0] c_CMP  = 4'b1011;
  localparam logic [3:0] c_MOV  = 4'b1101;
  localparam logic [3:0] c_LUI  = 4'b1111;

  localparam int c_FLAG_N = 4;
  localparam int c_FLAG_Z = 3;
  localparam int c_FLAG_F = 2;
  localparam int c_FLAG_L = 1;
  localparam int c_FLAG_C = 0;

  logic [15:0] r_regs [16];
  logic [4:0]  r_flags;

  logic [15:0] w_a;
  logic [15:0] w_b;
  logic [15:0] w_regB;
  logic [3:0]  w_code;
  logic        w_isExt;
  logic [16:0] w_cin;
  logic [16:0] w_uSum;
  logic [16:0] w_sSum;
  logic [16:0] w_uDiff;
  logic [16:0] w_sDiff;
  logic [4:0]  w_shMag;
  logic [15:0] w_lsh;
  logic [15:0] w_result;
  logic        w_write;
  logic        w_updC;
  logic        w_updF;
  logic        w_updCmp;
  logic        w_carry;
  logic        w_ovf;
  logic        w_destOk;
  logic        w_unused;

`ifdef REG0_ZERO_EN
  assign w_a      = (buffAEnables[3:0] == 4'd0) ? 16'h0000 : r_regs[buffAEnables[3:0]];
  assign w_regB   = (buffBEnables[3:0] == 4'd0) ? 16'h0000 : r_regs[buffBEnables[3:0]];
  assign w_destOk = ~regEnables[4] & (regEnables[3:0] != 4'd0);
`else
  assign w_a      = r_regs[buffAEnables[3:0]];
  assign w_regB   = r_regs[buffBEnables[3:0]];
  assign w_destOk = ~regEnables[4];
`endif

  assign w_b      = regOrImmed ? w_regB : immediate;
  assign w_unused = buffAEnables[4] ^ buffBEnables[4];

  assign w_isExt = (op == 4'b0000);
  assign w_code  = w_isExt ? exop : op;
  assign w_cin   = {16'd0, Cin & ((w_code == c_ADDC) || (w_code == c_SUBC))};

  // 17-bit unsigned forms expose carry/borrow; sign-extended forms expose overflow.
  assign w_uSum  = {1'b0, w_a} + {1'b0, w_b} + w_cin;
  assign w_sSum  = {w_a[15], w_a} + {w_b[15], w_b} + w_cin;
  assign w_uDiff = {1'b0, w_a} - {1'b0, w_b} - w_cin;
  assign w_sDiff = {w_a[15], w_a} - {w_b[15], w_b} - w_cin;

  assign w_shMag = ~w_b[4:0] + 5'd1;
  assign w_lsh   = w_b[4] ? (w_a >> w_shMag) : (w_a << w_b[3:0]);

  always_comb begin
    w_result = 16'h0000;
    w_write  = 1'b0;
    w_updC   = 1'b0;
    w_updF   = 1'b0;
    w_updCmp = 1'b0;
    w_carry  = 1'b0;
    w_ovf    = 1'b0;
    case (w_code)
      c_ADD, c_ADDC: begin
        w_result = w_uSum[15:0];
        w_write  = 1'b1;
        w_updC   = 1'b1;
        w_updF   = 1'b1;
        w_carry  = w_uSum[16];
        w_ovf    = w_sSum[16] ^ w_sSum[15];
      end
      c_ADDU: begin
        w_result = w_uSum[15:0];
        w_write  = 1'b1;
        w_updC   = 1'b1;
        w_carry  = w_uSum[16];
      end
      c_SUB, c_SUBC: begin
        w_result = w_uDiff[15:0];
        w_write  = 1'b1;
        w_updC   = 1'b1;
        w_updF   = 1'b1;
        w_carry  = w_uDiff[16];
        w_ovf    = w_sDiff[16] ^ w_sDiff[15];
      end
      c_CMP: w_updCmp = 1'b1;
      c_AND: begin w_result = w_a & w_b; w_write = 1'b1; end
      c_OR:  begin w_result = w_a | w_b; w_write = 1'b1; end
      c_XOR: begin w_result = w_a ^ w_b; w_write = 1'b1; end
      c_MOV: begin w_result = w_b;       w_write = 1'b1; end
      // Shift and LUI encodings differ between the extended and primary maps.
      c_LSH:  if (w_isExt)  begin w_result = w_lsh;               w_write = 1'b1; end
      c_LSHI: if (!w_isExt) begin w_result = w_lsh;               w_write = 1'b1; end
      c_LUI:  if (!w_isExt) begin w_result = {w_b[7:0], 8'h00};   w_write = 1'b1; end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int i = 0; i < 16; i++) r_regs[i] <= 16'h0000;
      r_flags <= 5'b00000;
    end else begin
      if (w_write && w_destOk) r_regs[regEnables[3:0]] <= w_result;
      if (w_updC) r_flags[c_FLAG_C] <= w_carry;
      if (w_updF) r_flags[c_FLAG_F] <= w_ovf;
      if (w_updCmp) begin
        r_flags[c_FLAG_Z] <= (w_a == w_b);
        r_flags[c_FLAG_L] <= (w_a < w_b);
        r_flags[c_FLAG_N] <= ($signed(w_a) < $signed(w_b));
      end
    end
  end

  assign flagsOutput = r_flags;
  assign regOut15    = r_regs[15];

endmodule

`default_nettype wire

// File: tb/tb_alu_reg_integration.sv
// ============================================================================
// Module   : tb_alu_reg_integration
// Purpose  : Scoreboard bench for alu_reg_integration with a reference model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_alu_reg_integration;

  logic        clock = 1'b0;
  logic        reset;
  logic [15:0] immediate;
  logic [4:0]  regEnables;
  logic [4:0]  buffAEnables;
  logic [4:0]  buffBEnables;
  logic        Cin;
  logic        regOrImmed;
  logic [3:0]  op;
  logic [3:0]  exop;
  logic [4:0]  flagsOutput;
  logic [15:0] regOut15;

  alu_reg_integration dut (
    .clock(clock), .reset(reset), .immediate(immediate),
    .regEnables(regEnables), .buffAEnables(buffAEnables),
    .buffBEnables(buffBEnables), .Cin(Cin), .regOrImmed(regOrImmed),
    .op(op), .exop(exop), .flagsOutput(flagsOutput), .regOut15(regOut15)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [15:0] r15;
    logic [4:0]  fl;
    string       tag;
  } exp_t;

  exp_t expQ[$];
  int   checks = 0;
  int   failures = 0;

  int   mRegs [16];
  bit   mN, mZ, mF, mL, mC;

  function automatic int readReg(input logic [3:0] idx);
`ifdef REG0_ZERO_EN
    if (idx == 4'd0) return 0;
`endif
    return mRegs[idx];
  endfunction

  function automatic string kindOf(input logic [3:0] o, input logic [3:0] e);
    logic [3:0] k;
    k = (o == 4'd0) ? e : o;
    if (k == 4'b0101) return "ADD";
    if (k == 4'b0110) return "ADDU";
    if (k == 4'b0111) return "ADDC";
    if (k == 4'b1001) return "SUB";
    if (k == 4'b1010) return "SUBC";
    if (k == 4'b1011) return "CMP";
    if (k == 4'b0001) return "AND";
    if (k == 4'b0010) return "OR";
    if (k == 4'b0011) return "XOR";
    if (k == 4'b1101) return "MOV";
    if (o == 4'd0 && k == 4'b0100) return "LSH";
    if (o != 4'd0 && k == 4'b1000) return "LSH";
    if (o != 4'd0 && k == 4'b1111) return "LUI";
    return "NOP";
  endfunction

  function automatic int toSigned(input int v);
    return (v >= 32768) ? v - 65536 : v;
  endfunction

  // Drives one cycle of controls (called at a falling edge), advances the model.
  task automatic issue(input bit rstN, input logic [15:0] imm, input logic [4:0] wr,
                       input logic [3:0] ra, input logic [3:0] rb, input bit ci,
                       input bit useReg, input logic [3:0] o, input logic [3:0] e,
                       input string tag);
    string kind;
    int a, b, c, res, s, full;
    bit writes;
    exp_t ex;
    reset        = rstN;
    immediate    = imm;
    regEnables   = wr;
    buffAEnables = {($urandom_range(0, 1) == 1) ? 1'b1 : 1'b0, ra};
    buffBEnables = {($urandom_range(0, 1) == 1) ? 1'b1 : 1'b0, rb};
    Cin          = ci;
    regOrImmed   = useReg;
    op           = o;
    exop         = e;
    if (!rstN) begin
      for (int i = 0; i < 16; i++) mRegs[i] = 0;
      {mN, mZ, mF, mL, mC} = 5'b00000;
    end else begin
      kind   = kindOf(o, e);
      a      = readReg(ra);
      b      = useReg ? readReg(rb) : int'(imm);
      c      = (kind == "ADDC" || kind == "SUBC") ? int'(ci) : 0;
      writes = 1'b1;
      res    = 0;
      if (kind == "ADD" || kind == "ADDC" || kind == "ADDU") begin
        full = a + b + c;
        res  = full % 65536;
        mC   = (full > 65535);
        if (kind != "ADDU") begin
          s  = toSigned(a) + toSigned(b) + c;
          mF = (s > 32767 || s < -32768);
        end
      end else if (kind == "SUB" || kind == "SUBC") begin
        full = a - b - c;
        res  = (full + 65536) % 65536;
        mC   = (full < 0);
        s    = toSigned(a) - toSigned(b) - c;
        mF   = (s > 32767 || s < -32768);
      end else if (kind == "CMP") begin
        writes = 1'b0;
        mZ = (a == b);
        mL = (a < b);
        mN = (toSigned(a) < toSigned(b));
      end else if (kind == "AND") res = a & b;
      else if (kind == "OR")  res = a | b;
      else if (kind == "XOR") res = a ^ b;
      else if (kind == "MOV") res = b;
      else if (kind == "LUI") res = (b % 256) * 256;
      else if (kind == "LSH") begin
        s = b % 32;
        if (s >= 16) s = s - 32;
        if (s >= 0)        res = (a << s) % 65536;
        else if (s <= -16) res = 0;
        else               res = a >> (-s);
      end else writes = 1'b0;
`ifdef REG0_ZERO_EN
      if (wr[3:0] == 4'd0) writes = 1'b0;
`endif
      if (writes && !wr[4]) mRegs[wr[3:0]] = res;
    end
    ex.r15 = mRegs[15][15:0];
    ex.fl  = {mN, mZ, mF, mL, mC};
    ex.tag = tag;
    expQ.push_back(ex);
    @(negedge clock);
  endtask

  task automatic checkNow(input string tag, input logic [15:0] r15, input logic [4:0] fl);
    checks++;
    if (regOut15 !== r15 || flagsOutput !== fl) begin
      failures++;
      $display("FAIL %s: got r15=%h flags=%b, want r15=%h flags=%b",
               tag, regOut15, flagsOutput, r15, fl);
    end
  endtask

  // Monitor: every rising edge retires the oldest outstanding expectation.
  initial begin
    exp_t ex;
    forever begin
      @(posedge clock);
      #1;
      if (expQ.size() > 0) begin
        ex = expQ.pop_front();
        checks++;
        if (regOut15 !== ex.r15) begin
          failures++;
          $display("FAIL %s r15: got %h want %h", ex.tag, regOut15, ex.r15);
        end
        checks++;
        if (flagsOutput !== ex.fl) begin
          failures++;
          $display("FAIL %s flags: got %b want %b", ex.tag, flagsOutput, ex.fl);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    logic [3:0] o, e;
    reset = 1'b0; immediate = '0; regEnables = 5'h10; buffAEnables = '0;
    buffBEnables = '0; Cin = 1'b0; regOrImmed = 1'b0; op = '0; exop = '0;
    @(negedge clock);

    issue(1'b0, 16'h0000, 5'h10, 4'd0, 4'd0, 1'b0, 1'b0, 4'h0, 4'h0, "reset");
    checkNow("reset_state", 16'h0000, 5'b00000);

    // Fibonacci chain into R15.
    issue(1'b1, 16'h0001, 5'd0, 4'd0, 4'd0, 1'b0, 1'b0, 4'b0101, 4'h0, "addi_r0");
    issue(1'b1, 16'h0001, 5'd1, 4'd0, 4'd0, 1'b0, 1'b0, 4'b1101, 4'h0, "movi_r1");
    for (int n = 2; n < 16; n++)
      issue(1'b1, 16'h0000, 5'(n), 4'(n - 1), 4'(n - 2), 1'b0, 1'b1, 4'h0, 4'b0101, "fib");
`ifndef REG0_ZERO_EN
    checkNow("fib_r15", 16'h03DB, 5'b00000);
`endif

    issue(1'b1, 16'h7FFF, 5'd2, 4'd0, 4'd0, 1'b0, 1'b0, 4'b1101, 4'h0, "movi_r2");
    issue(1'b1, 16'h0001, 5'd15, 4'd2, 4'd0, 1'b0, 1'b0, 4'b0101, 4'h0, "addi_ovf");
    checkNow("add_overflow", 16'h8000, 5'b00100);
    issue(1'b1, 16'hFFFF, 5'd3, 4'd0, 4'd0, 1'b0, 1'b0, 4'b1101, 4'h0, "movi_r3");
    issue(1'b1, 16'h0000, 5'd15, 4'd3, 4'd0, 1'b1, 1'b0, 4'h0, 4'b0111, "addc_carry");
    checkNow("addc_carry", 16'h0000, 5'b00001);

    issue(1'b1, 16'h0005, 5'd4, 4'd0, 4'd0, 1'b0, 1'b0, 4'b1101, 4'h0, "movi_r4");
    issue(1'b1, 16'h0007, 5'd5, 4'd0, 4'd0, 1'b0, 1'b0, 4'b1101, 4'h0, "movi_r5");
    issue(1'b1, 16'h0000, 5'd15, 4'd4, 4'd5, 1'b0, 1'b1, 4'h0, 4'b1011, "cmp_lt");
    checkNow("cmp_5_7", 16'h0000, 5'b10011);
    issue(1'b1, 16'h0000, 5'd15, 4'd5, 4'd5, 1'b0, 1'b1, 4'h0, 4'b1011, "cmp_eq");
    checkNow("cmp_7_7", 16'h0000, 5'b01001);

    issue(1'b1, 16'h5555, 5'h1F, 4'd0, 4'd0, 1'b0, 1'b0, 4'b1101, 4'h0, "write_off");
    checkNow("write_suppress", 16'h0000, 5'b01001);
    issue(1'b1, 16'h1234, 5'd15, 4'd0, 4'd0, 1'b0, 1'b0, 4'b1101, 4'h0, "movi_r15");
    checkNow("movi_1234", 16'h1234, 5'b01001);
    issue(1'b0, 16'h0001, 5'd15, 4'd15, 4'd0, 1'b0, 1'b0, 4'b0101, 4'h0, "reset_mid");
    checkNow("reset_mid_op", 16'h0000, 5'b00000);

    issue(1'b1, 16'h0001, 5'd15, 4'd0, 4'd0, 1'b0, 1'b0, 4'b1101, 4'h0, "movi_1");
    issue(1'b1, 16'h0003, 5'd15, 4'd15, 4'd0, 1'b0, 1'b0, 4'b1000, 4'h0, "lshi_3");
    checkNow("lsh_left3", 16'h0008, 5'b00000);
    issue(1'b1, 16'h001F, 5'd15, 4'd15, 4'd0, 1'b0, 1'b0, 4'b1000, 4'h0, "lshi_m1");
    checkNow("lsh_right1", 16'h0004, 5'b00000);
    issue(1'b1, 16'h00AB, 5'd15, 4'd0, 4'd0, 1'b0, 1'b0, 4'b1111, 4'h0, "lui");
    checkNow("lui", 16'hAB00, 5'b00000);

    // Randomized traffic; periodic MOVs copy a random register into R15 for visibility.
    for (int i = 0; i < 400; i++) begin
      if (i % 6 == 5) begin
        issue(1'b1, 16'($urandom), 5'd15, 4'($urandom), 4'($urandom), 1'b0, 1'b1,
              4'h0, 4'b1101, "rand_expose");
      end else begin
        if ($urandom_range(0, 2) == 0) begin
          o = 4'h0;
          e = 4'($urandom);
        end else begin
          o = 4'($urandom);
          e = 4'($urandom);
        end
        issue(($urandom_range(0, 59) != 0), 16'($urandom), 5'($urandom_range(0, 19) == 0 ? 5'h10 | 5'($urandom) : 5'($urandom_range(0, 15))),
              4'($urandom), 4'($urandom), 1'($urandom), 1'($urandom), o, e, "rand_op");
      end
    end

    @(negedge clock);
    checks++;
    if (expQ.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d expectations left, want 0", expQ.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/alu_reg_integration.md
Name: alu_reg_integration

Overview:
- Single-cycle datapath pairing a 16 x 16-bit register file with a CR16-style 16-bit ALU.
- Each clock edge reads operand A from a register and operand B from a register or the external immediate, executes `op`/`exop`, and writes the result back to a selected register.
- Flags are registered, and R15 is exported for observation.
- Sits under the processor control unit, which drives all select/enable inputs directly.

Parameters:
- None. Data width is fixed at 16 bits; register count is fixed at 16.

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-low reset
- immediate  in  16  immediate operand
- regEnables  in  5  write select: [3:0] = destination index; [4]=1 suppresses the write
- buffAEnables  in  5  [3:0] = operand-A register index; [4] ignored
- buffBEnables  in  5  [3:0] = operand-B register index; [4] ignored
- Cin  in  1  carry-in for ADDC/SUBC
- regOrImmed  in  1  1: B = R[buffB]; 0: B = immediate
- op  in  4  primary opcode
- exop  in  4  extended opcode, used when op=0000
- flagsOutput  out  5  registered flags {N,Z,F,L,C} = bits [4:0]
- regOut15  out  16  current contents of R15

Behaviour:
- Reset
  - reset low at a rising edge clears R0–R15 and flags to 0.
  - Reset has priority over any write or flag update that cycle.
  - Mid-operation reset discards the in-flight result.
- Operand selection (all combinational):
  - A = R[buffAEnables[3:0]]
  - B = regOrImmed ? R[buffBEnables[3:0]] : immediate
- Operation decode:
  - When op=0000, the operation comes from exop: 0101 ADD, 0110 ADDU, 0111 ADDC, 1001 SUB, 1010 SUBC, 1011 CMP, 0001 AND, 0010 OR, 0011 XOR, 1101 MOV, 0100 LSH.
  - When op≠0000, the same codes apply on op directly (ADDI=0101, ADDUI=0110, ADDCI=0111, SUBI=1001, SUBCI=1010, CMPI=1011, ANDI=0001, ORI=0010, XORI=0011, MOVI=1101, LSHI=1000).
  - LUI=1111 gives result = {B[7:0], 8'h00}.
  - Any other code is a NOP: no write, flags unchanged.
- Arithmetic (mod 2^16):
  - ADD/ADDU: A+B.
  - ADDC: A+B+Cin.
  - SUB: A−B.
  - SUBC: A−B−Cin.
  - MOV: B.
  - AND/OR/XOR: bitwise.
  - LSH: B[4:0] is signed. Positive values shift A left; negative values shift A right logically. Magnitude ≥16 gives 0.
- Write-back:
  - Result is written to R[regEnables[3:0]] at the rising edge when regEnables[4]=0 and the op writes.
  - CMP/CMPI and NOPs never write.
  - Reads during a write cycle return the pre-edge value.
  - Write to the same register as a source (e.g. R3=R3+R3) is legal.
- Flags (registered, updated at the edge of an executing op):
  - ADD/ADDC/SUB/SUBC (and immediates): C = unsigned carry-out/borrow; F = signed overflow.
  - ADDU/ADDUI: update C only.
  - CMP: Z = (A==B); L = A<B unsigned; N = A<B signed.
  - All other ops leave flags unchanged.
- regOut15 is a combinational view of R15; it shows a new value immediately after the writing edge.
- Latency: one clock from controls to register/flag update; no stall or handshake.

Optional Feature:
- Macro: REG0_ZERO_EN.
- Defined: R0 reads as 0 on both ports, and writes to index 0 are discarded.
- Undefined: R0 is an ordinary register.

Test Plan:
- Reset low one edge, then release → regOut15=0, flagsOutput=0.
- ADDI R0 (A=0, imm=1, dest=0) and MOVI R1 (imm=1, dest=1), then 14 ADDs building Rn=R(n−1)+R(n−2) into R2..R15 → regOut15=987 (0x03DB).
- R2=0x7FFF; ADD with immediate 1 → result 0x8000, F=1, C=0. Then R3=0xFFFF; ADDC with B=0, Cin=1 → 0x0000, C=1.
- CMP A=5, B=7 → no write, flagsOutput Z=0, L=1, N=1. CMP A=7, B=7 → Z=1, L=0, N=0.
- Write with regEnables=5'b1_1111 → R15 unchanged. MOV immediate 0x1234 to R15, then assert reset low the next edge while an ADD is targeting R15 → R15=0.
- LSH R15=0x0001 by B=3 → 0x0008; by B=5'b11111 (−1) → 0x0004. LUI imm=0x00AB → 0xAB00.
